// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg : glyph table, dark code and display data-set type for seg_scan_driver
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_DARK = 7'b1111111;

  // Active-low {a,b,c,d,e,f,g}; element 0 is the glyph for code 0.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] digits;
    logic [MAX_DIGITS-1:0]   blank;
    logic [MAX_DIGITS-1:0]   blink;
    logic [MAX_DIGITS-1:0]   dp;
    logic                    hex_mode;
    logic                    lz_suppress;
  } disp_set_t;

  localparam disp_set_t SET_RESET = '{
    digits:      '0,
    blank:       '1,
    blink:       '0,
    dp:          '0,
    hex_mode:    1'b0,
    lz_suppress: 1'b0
  };

endpackage

`default_nettype wire

// File: rtl/seg_glyph.sv
// ----------------------------------------------------------------------------
// seg_glyph : combinational 4-bit code to active-low 7-segment glyph
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg_glyph
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  output logic [6:0] segments
);

  always_comb begin
    segments = GLYPH_TABLE[code];
    if (!hex_mode && (code > 4'd9)) segments = SEG_DARK;
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seg_scan_driver : multiplexed 7-segment scanner with frame-synchronous loads
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    hex_mode_i,
  input  logic                    lz_suppress_i,
  input  logic                    load_i,
  output logic [6:0]              segment_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_next;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_on;
  logic                  blink_on_next;
  disp_set_t             shadow;
  disp_set_t             active;
  disp_set_t             captured;
  disp_set_t             active_next;
  logic                  tc;
  logic                  wrap;
  logic                  chain;
  logic [MAX_DIGITS-1:0] supp;
  logic                  visible;
  logic [3:0]            code;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] sel_next;

  assign tc       = (presc == PRESC_LAST);
  assign wrap     = tc && (idx == IDX_LAST);
  assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  always_comb begin
    captured                          = '0;
    captured.digits[4*NUM_DIGITS-1:0] = digits_i;
    captured.blank[NUM_DIGITS-1:0]    = blank_i;
    captured.blink[NUM_DIGITS-1:0]    = blink_i;
    captured.dp[NUM_DIGITS-1:0]       = dp_i;
    captured.hex_mode                 = hex_mode_i;
    captured.lz_suppress              = lz_suppress_i;
  end

  // Data seen by the slot about to start; a load on the wrap cycle bypasses the shadow.
  always_comb begin
    active_next   = active;
    blink_on_next = blink_on;
    if (wrap) begin
      if (load_i)       active_next = captured;
      else if (pending_o) active_next = shadow;
      if (blink_cnt == BLINK_LAST) blink_on_next = !blink_on;
    end
  end

  always_comb begin
    supp  = '0;
    chain = active_next.lz_suppress;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      chain   = chain && (active_next.digits[4*i +: 4] == 4'd0) && !active_next.dp[i];
      supp[i] = chain;
    end
  end

  assign code    = active_next.digits[{idx_next, 2'b00} +: 4];
  assign visible = !active_next.blank[idx_next]
                && !(active_next.blink[idx_next] && !blink_on_next)
                && !supp[idx_next];

  seg_glyph u_glyph (
    .code     (code),
    .hex_mode (active_next.hex_mode),
    .segments (glyph)
  );

  // Enable is registered, so the guard window ends one prescaler count early.
  always_comb begin
    sel_next = '1;
    if (tc) begin
      if (GUARD == 0) sel_next[idx_next] = 1'b0;
    end else if (int'(presc) >= GUARD - 1) begin
      sel_next[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      shadow      <= '0;
      active      <= SET_RESET;
      pending_o   <= 1'b0;
      segment_o   <= SEG_DARK;
      dp_o        <= 1'b1;
      digit_sel_o <= '1;
      frame_o     <= 1'b0;
    end else begin
      presc       <= tc ? '0 : presc + 1'b1;
      frame_o     <= wrap;
      digit_sel_o <= sel_next;
      active      <= active_next;
      blink_on    <= blink_on_next;
      if (tc) begin
        idx       <= idx_next;
        segment_o <= visible ? glyph : SEG_DARK;
        dp_o      <= !(visible && active_next.dp[idx_next]);
      end
      if (wrap) blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
      if (load_i && !wrap) begin
        shadow    <= captured;
        pending_o <= 1'b1;
      end else if (wrap) begin
        pending_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_driver : randomized bench with a cycle-count based display model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int GD    = 1;
  localparam int BF    = 2;
  localparam int FRAME = ND * SD;
  localparam logic [13:0] RESET_OBS = {7'b1111111, 1'b1, 4'b1111, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  blink = '0;
  logic [3:0]  dp = '0;
  logic        hex_mode = 1'b0;
  logic        lz_suppress = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  segment_o;
  logic        dp_o;
  logic [3:0]  digit_sel_o;
  logic        frame_o;
  logic        pending_o;
  logic [13:0] obs;

  seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .GUARD        (GD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .digits_i      (digits),
    .blank_i       (blank),
    .blink_i       (blink),
    .dp_i          (dp),
    .hex_mode_i    (hex_mode),
    .lz_suppress_i (lz_suppress),
    .load_i        (load),
    .segment_o     (segment_o),
    .dp_o          (dp_o),
    .digit_sel_o   (digit_sel_o),
    .frame_o       (frame_o),
    .pending_o     (pending_o)
  );

  assign obs = {segment_o, dp_o, digit_sel_o, frame_o, pending_o};

  always #5 clk = ~clk;

  typedef struct {
    int          target;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic [3:0]  dp;
    logic        hex;
    logic        lz;
  } load_t;

  load_t loads[$];
  int    ecount;
  int    n_checks;
  int    n_fail;

  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Expected outputs after edge number ecount (counted from reset release).
  function automatic logic [13:0] expected();
    load_t      cur;
    int         f, d, k, val;
    bit         phase, supp, vis;
    logic [6:0] seg;
    logic [3:0] sel;
    logic       dpo, frm, pend;
    cur = '{target: 0, digits: 16'h0, blank: 4'hF, blink: 4'h0, dp: 4'h0, hex: 1'b0, lz: 1'b0};
    f = ecount / FRAME;
    d = (ecount / SD) % ND;
    k = ecount % SD;
    foreach (loads[i]) if (loads[i].target <= f) cur = loads[i];
    pend = (loads.size() > 0) && (loads[loads.size()-1].target > f);
    frm  = (ecount > 0) && (ecount % FRAME == 0);
    sel  = 4'hF;
    if (ecount > 0 && k >= GD) sel[d] = 1'b0;
    seg = 7'h7F;
    dpo = 1'b1;
    if (ecount >= SD) begin
      phase = ((f / BF) % 2) == 0;
      supp  = cur.lz && (d > 0);
      for (int j = ND - 1; j >= d; j--)
        if (cur.digits[4*j +: 4] != 4'd0 || cur.dp[j]) supp = 1'b0;
      vis = !cur.blank[d] && !(cur.blink[d] && !phase) && !supp;
      val = int'(cur.digits[4*d +: 4]);
      if (vis) begin
        seg = (cur.hex || val < 10) ? glyph_tab[val] : 7'h7F;
        dpo = !cur.dp[d];
      end
    end
    return {seg, dpo, sel, frm, pend};
  endfunction

  task automatic tick();
    @(posedge clk);
    ecount++;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic issue_load(input logic [15:0] dg, input logic [3:0] bl, input logic [3:0] bk,
                            input logic [3:0] p, input logic hx, input logic lz);
    load_t r;
    int    e;
    e           = ecount + 1;
    digits      = dg;
    blank       = bl;
    blink       = bk;
    dp          = p;
    hex_mode    = hx;
    lz_suppress = lz;
    load        = 1'b1;
    r = '{target: (e % FRAME == 0) ? e / FRAME : e / FRAME + 1,
          digits: dg, blank: bl, blink: bk, dp: p, hex: hx, lz: lz};
    loads.push_back(r);
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_values: got %b want %b", obs, RESET_OBS);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    ecount = 0;
    loads.delete();
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      exp = expected();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_dark cycle %0d: got %b want %b", ecount, obs, exp);
      end
    end
  endtask

  task automatic test_basic();
    logic [13:0] exp;
    int          pulses = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (c == 0) issue_load(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      tick();
      if (frame_o === 1'b1) pulses++;
      exp = expected();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL basic_1234 cycle %0d: got %b want %b", ecount, obs, exp);
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL frame_rate: got %0d pulses want 3", pulses);
    end
  endtask

  task automatic test_lz_hex();
    logic [13:0] exp;
    logic [15:0] pd  [4] = '{16'h0007, 16'h0007, 16'h00AF, 16'h00AF};
    logic [3:0]  pdp [4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000};
    logic        phx [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        plz [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 3 * FRAME; c++) begin
        if (c == 0) issue_load(pd[p], 4'h0, 4'h0, pdp[p], phx[p], plz[p]);
        tick();
        exp = expected();
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL lz_hex pattern %0d cycle %0d: got %b want %b", p, ecount, obs, exp);
        end
      end
    end
  endtask

  task automatic test_pending();
    logic [13:0] exp;
    int          stage = 0;
    bit          was_mid, was_wrap;
    for (int c = 0; c < 5 * FRAME; c++) begin
      was_mid  = 1'b0;
      was_wrap = 1'b0;
      if (stage == 0 && ecount % FRAME == 5) begin
        issue_load(16'h5678, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0);
        stage = 1; was_mid = 1'b1;
      end else if (stage == 1 && (ecount + 1) % FRAME == 0) begin
        issue_load(16'h9ABC, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        stage = 2; was_wrap = 1'b1;
      end else if (stage == 2 && ecount % FRAME == 3) begin
        issue_load(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        stage = 3;
      end else if (stage == 3 && ecount % FRAME == 9) begin
        issue_load(16'h0DEF, 4'h0, 4'h0, 4'h8, 1'b1, 1'b1);
        stage = 4;
      end
      tick();
      exp = expected();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL pending_seq cycle %0d: got %b want %b", ecount, obs, exp);
      end
      if (was_mid) begin
        n_checks++;
        if (pending_o !== 1'b1) begin
          n_fail++;
          $display("FAIL pending_set: got %b want 1", pending_o);
        end
      end
      if (was_wrap) begin
        n_checks++;
        if ({pending_o, frame_o} !== 2'b01) begin
          n_fail++;
          $display("FAIL load_on_wrap: got pending=%b frame=%b want pending=0 frame=1", pending_o, frame_o);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [13:0] exp;
    for (int c = 0; c < 9 * FRAME; c++) begin
      if (c == 0) issue_load(16'h1234, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0);
      tick();
      exp = expected();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL blink cycle %0d: got %b want %b", ecount, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [13:0] exp;
    bit          go;
    for (int c = 0; c < 1600; c++) begin
      go = ($urandom_range(0, 11) == 0) || (((ecount + 1) % FRAME == 0) && $urandom_range(0, 2) == 0);
      if (go)
        issue_load(16'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                   ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, 4'($urandom),
                   1'($urandom), 1'($urandom));
      tick();
      exp = expected();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b want %b", ecount, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] exp;
    for (int c = 0; c < 2 * FRAME + 6; c++) begin
      if (c == 0) issue_load(16'h8888, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_async: got %b want %b", obs, RESET_OBS);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    ecount = 0;
    loads.delete();
    for (int c = 0; c < 5 * FRAME; c++) begin
      if (c == 3 * FRAME) issue_load(16'h4321, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      tick();
      exp = expected();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_restart cycle %0d: got %b want %b", ecount, obs, exp);
      end
    end
  endtask

  initial begin
    ecount   = 0;
    n_checks = 0;
    n_fail   = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_lz_hex();
    test_pending();
    test_blink();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
